// File: rtl/decoder_scan_n_pkg.sv
// decoder_pkg: modes, FSM states and one-hot helper shared by the decoder_scan_n slice
package decoder_pkg;
    localparam int SEL_MAX = 8;
    typedef enum logic [1:0] {MODE_LEVEL, MODE_PULSE, MODE_SCAN, MODE_RSVD} mode_e;
    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_PULSE, ST_SCAN} state_e;
    function automatic logic [(1 << SEL_MAX)-1:0] onehot(input logic [SEL_MAX-1:0] sel);
        logic [(1 << SEL_MAX)-1:0] r;
        r = '0;
        r[sel] = 1'b1;
        return r;
    endfunction
endpackage

// File: rtl/decoder_scan_n_if.sv
// decoder_scan_n_if: command and one-hot output bundle of decoder_scan_n
interface decoder_scan_n_if #(parameter int SEL_W = 3, parameter int DWELL_W = 8);
    localparam int OUT_W = 1 << SEL_W;
    logic en;
    logic load;
    logic [1:0] mode;
    logic [SEL_W-1:0] din;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_W-1:0] dout;
    logic [SEL_W-1:0] idx;
    logic wrap;
    logic busy;
    modport master (output en, load, mode, din, dwell, input dout, idx, wrap, busy);
    modport slave (input en, load, mode, din, dwell, output dout, idx, wrap, busy);
endinterface

// File: rtl/decoder_nto2n_core.sv
// decoder_nto2n_core: combinational SEL_W-to-2^SEL_W one-hot decode, zero when disabled
module decoder_nto2n_core import decoder_pkg::*; #(parameter int SEL_W = 3) (
    input  logic [SEL_W-1:0]        din,
    input  logic                    en,
    output logic [(1 << SEL_W)-1:0] dout
);
    localparam int OUT_W = 1 << SEL_W;
    assign dout = en ? OUT_W'(onehot(SEL_MAX'(din))) : '0;
endmodule

// File: rtl/decoder_scan_n.sv
// decoder_scan_n: registered one-hot decoder with level, pulse and auto-scan modes
module decoder_scan_n import decoder_pkg::*; #(parameter int SEL_W = 3, parameter int DWELL_W = 8) (
    input logic clk,
    input logic rst_n,
    decoder_scan_n_if.slave bus
);
    localparam int OUT_W = 1 << SEL_W;
    state_e st, st_nx;
    mode_e m;
    logic [SEL_W-1:0] idx_q, idx_nx;
    logic [DWELL_W-1:0] cnt, cnt_nx, dw, dw_nx;
    logic [OUT_W-1:0] dout_q, dout_nx;
    logic wrap_q, wrap_nx, busy_q;
    assign m = mode_e'(bus.mode);
    always_comb begin
        st_nx = st;
        idx_nx = idx_q;
        cnt_nx = cnt;
        dw_nx = dw;
        wrap_nx = 1'b0;
        if (!bus.en) begin
            st_nx = ST_IDLE;
            cnt_nx = '0;
        end else if (bus.load) begin
            st_nx = m == MODE_LEVEL ? ST_HOLD : m == MODE_PULSE ? ST_PULSE : m == MODE_SCAN ? ST_SCAN : ST_IDLE;
            idx_nx = bus.din;
            cnt_nx = '0;
            dw_nx = m == MODE_SCAN ? bus.dwell : dw;
        end else if (st == ST_PULSE) begin
            st_nx = ST_IDLE;
        end else if (st == ST_SCAN) begin
            cnt_nx = cnt == dw ? '0 : cnt + 1'b1;
            idx_nx = cnt == dw ? idx_q + 1'b1 : idx_q;
            wrap_nx = cnt == dw && &idx_q;
        end
        // idle always reports index 0 so dout/idx never disagree
        idx_nx = st_nx == ST_IDLE ? '0 : idx_nx;
    end
    decoder_nto2n_core #(.SEL_W(SEL_W)) u_core (
        .din (idx_nx),
        .en  (st_nx != ST_IDLE),
        .dout(dout_nx)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= ST_IDLE;
            idx_q <= '0;
            cnt <= '0;
            dw <= '0;
            dout_q <= '0;
            wrap_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            st <= st_nx;
            idx_q <= idx_nx;
            cnt <= cnt_nx;
            dw <= dw_nx;
            dout_q <= dout_nx;
            wrap_q <= wrap_nx;
            busy_q <= st_nx != ST_IDLE;
        end
    end
    assign bus.dout = dout_q;
    assign bus.idx = idx_q;
    assign bus.wrap = wrap_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_decoder_scan_n.sv
// tb_decoder_scan_n: closed-form reference model plus directed and random checks of decoder_scan_n
module tb_decoder_scan_n;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    bit chk_on = 1'b0;
    int total = 0;
    int bad = 0;
    int mk = 0, ms = 0, md = 0, mt = 0;
    decoder_scan_n_if #(.SEL_W(3), .DWELL_W(8)) bus ();
    decoder_scan_n #(.SEL_W(3), .DWELL_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
        end
    endtask

    // model: kind 0 idle, 1 hold, 2 pulse, 3 scan; scan position is derived from elapsed cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mk = 0;
        else if (!bus.en) mk = 0;
        else if (bus.load) begin
            ms = int'(bus.din);
            mk = bus.mode == 2'd0 ? 1 : bus.mode == 2'd1 ? 2 : bus.mode == 2'd2 ? 3 : 0;
            if (bus.mode == 2'd2) begin
                md = int'(bus.dwell);
                mt = 0;
            end
        end else if (mk == 2) mk = 0;
        else if (mk == 3) mt++;
    end

    always @(negedge clk) begin
        int ei;
        logic [7:0] ed;
        if (chk_on) begin
            ei = mk == 0 ? 0 : mk == 3 ? (ms + mt / (md + 1)) % 8 : ms;
            ed = mk == 0 ? 8'h00 : 8'(1 << ei);
            chk("m_dout", bus.dout, ed);
            chk("m_idx", bus.idx, ei);
            chk("m_busy", bus.busy, mk != 0);
            chk("m_wrap", bus.wrap, mk == 3 && mt > 0 && mt % (md + 1) == 0 && ei == 0);
            chk("onehot", bus.dout == 8'h00 || bus.dout == 8'(1 << bus.idx), 1);
        end
    end

    initial begin
        logic [7:0] ex [7];
        int n;
        ex = '{8'h40, 8'h40, 8'h40, 8'h80, 8'h80, 8'h80, 8'h01};
        bus.en = 1'b0; bus.load = 1'b0; bus.mode = 2'd0; bus.din = '0; bus.dwell = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dout", bus.dout, 8'h00);
        chk("rst_idx", bus.idx, 0);
        chk("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        chk_on = 1'b1;
        bus.en = 1'b1; bus.load = 1'b1; bus.mode = 2'd0; bus.din = 3'd5;
        @(negedge clk);
        bus.load = 1'b0;
        chk("lvl_dout", bus.dout, 8'h20);
        chk("lvl_idx", bus.idx, 5);
        chk("lvl_busy", bus.busy, 1);
        bus.din = 3'd2;
        repeat (20) begin
            @(negedge clk);
            chk("lvl_hold", bus.dout, 8'h20);
        end
        bus.load = 1'b1; bus.mode = 2'd1; bus.din = 3'd1;
        @(negedge clk);
        chk("pls_1", bus.dout, 8'h02);
        bus.din = 3'd4;
        @(negedge clk);
        chk("pls_4", bus.dout, 8'h10);
        bus.din = 3'd7;
        @(negedge clk);
        chk("pls_7", bus.dout, 8'h80);
        bus.load = 1'b0;
        @(negedge clk);
        chk("pls_end", bus.dout, 8'h00);
        chk("pls_busy", bus.busy, 0);
        bus.load = 1'b1; bus.mode = 2'd2; bus.din = 3'd6; bus.dwell = 8'd2;
        @(negedge clk);
        bus.load = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("scn_dout", bus.dout, ex[i]);
            chk("scn_wrap", bus.wrap, i == 6);
            if (i < 6) @(negedge clk);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.wrap && n < 40);
        chk("scn_period", n, 24);
        bus.load = 1'b1; bus.din = 3'd3; bus.dwell = 8'd0;
        @(negedge clk);
        bus.load = 1'b0;
        chk("rel_08", bus.dout, 8'h08);
        @(negedge clk);
        chk("rel_10", bus.dout, 8'h10);
        @(negedge clk);
        chk("rel_20", bus.dout, 8'h20);
        bus.en = 1'b0; bus.load = 1'b1; bus.mode = 2'd0; bus.din = 3'd5;
        @(negedge clk);
        chk("en_dout", bus.dout, 8'h00);
        chk("en_busy", bus.busy, 0);
        bus.en = 1'b1; bus.din = 3'd4;
        @(negedge clk);
        chk("lvl4", bus.dout, 8'h10);
        bus.mode = 2'd3;
        @(negedge clk);
        bus.load = 1'b0;
        chk("rsv_dout", bus.dout, 8'h00);
        chk("rsv_busy", bus.busy, 0);
        bus.load = 1'b1; bus.mode = 2'd2; bus.din = 3'd7; bus.dwell = 8'hff;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (255) @(negedge clk);
        chk("dmax_hold", bus.idx, 7);
        @(negedge clk);
        chk("dmax_idx", bus.idx, 0);
        chk("dmax_wrap", bus.wrap, 1);
        bus.load = 1'b1; bus.din = 3'd1; bus.dwell = 8'd5;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dout", bus.dout, 8'h00);
        chk("arst_busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2000) begin
            @(negedge clk);
            bus.en = $urandom_range(0, 15) != 0;
            bus.load = $urandom_range(0, 3) == 0;
            bus.mode = 2'($urandom_range(0, 3));
            bus.din = 3'($urandom_range(0, 7));
            bus.dwell = $urandom_range(0, 9) == 0 ? 8'hff : 8'($urandom_range(0, 3));
        end
        @(negedge clk);
        bus.en = 1'b1; bus.load = 1'b0;
        @(negedge clk);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decoder_scan_n.md
# decoder_scan_n

Parametrised, registered N-to-2^N one-hot decoder with three operating modes: level hold, single-cycle pulse, and auto-scan with a programmable dwell. It is the successor to the fixed 3-to-8 combinational decoder. It sits between control logic and one-hot consumers: chip-selects, strobes to register banks, and row/digit select for multiplexed displays. All outputs are registered. Mode and operands are captured only on a `load` strobe.

## Interface
Parameters:
- `SEL_W`, default 3: select width; output width `OUT_W = 1 << SEL_W` (localparam, not overridable).
- `DWELL_W`, default 8: width of the scan dwell operand.

Ports:
- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: global enable; low forces idle.
- `load` input 1: command strobe; samples `mode`, `din`, `dwell`.
- `mode` input 2: 0 = LEVEL, 1 = PULSE, 2 = SCAN, 3 = reserved.
- `din` input SEL_W: index to decode (LEVEL/PULSE) or start index (SCAN).
- `dwell` input DWELL_W: SCAN only; each index is held for `dwell+1` cycles.
- `dout` output OUT_W: one-hot decoded output, or all zeros.
- `idx` output SEL_W: binary index currently driven on `dout`.
- `wrap` output 1: one-cycle pulse when SCAN rolls from index OUT_W-1 to 0.
- `busy` output 1: high whenever state is not IDLE.

## Operation
- States: IDLE, HOLD, PULSE, SCAN.
- Reset values: state IDLE, `dout` = 0, `idx` = 0, `wrap` = 0, `busy` = 0, dwell counter 0, captured dwell 0.
- Invariant: `dout` is either all zeros or exactly one-hot with bit `idx` set. Never multi-hot.
- `en` low has priority over everything, including `load`. Next edge: state IDLE, `dout` = 0, `idx` = 0, `wrap` = 0.
- `load` with `en` high from any state:
  - mode 0: go to HOLD, `idx` <= `din`, `dout` <= onehot(`din`).
  - mode 1: go to PULSE, same outputs as HOLD.
  - mode 2: go to SCAN, `idx` <= `din`, `dout` <= onehot(`din`), capture `dwell`, clear the dwell counter.
  - mode 3: go to IDLE, `dout` = 0.
- HOLD: outputs stay constant until the next `load` or `en` drops.
- PULSE: lasts one cycle, then returns to IDLE with `dout` = 0.
  - A `load` in the pulse cycle takes precedence, so back-to-back loads give consecutive one-cycle pulses with no gap.
- SCAN:
  - The dwell counter increments each cycle.
  - When it equals the captured dwell, it clears and `idx` <= `idx`+1 (modulo OUT_W), and `dout` follows.
  - `wrap` = 1 in exactly the first cycle that `idx` = 0 after a rollover. Starting at `din` = 0 does not assert `wrap`.
  - `load` during SCAN restarts from the new `din` and `dwell` and clears the counter.
- Changes to `mode`, `din` or `dwell` without `load` are ignored.

## Timing
- Latency from `load` to `dout`/`idx` is 1 cycle (registered); `busy` updates in the same cycle.
- Latency from `en` deassertion to `dout` = 0 is 1 cycle.
- Reset is asynchronous: asserting `rst_n` mid-scan or mid-pulse clears all outputs immediately, without waiting for a clock edge. Deassertion is synchronised externally.
- SCAN period per index is `dwell`+1 cycles. Full cycle is OUT_W × (`dwell`+1) cycles.
  - `dwell` = 0 advances every cycle.
  - `dwell` = 2^DWELL_W−1 is legal.
- Dwell counter width is DWELL_W. No overflow is possible because the compare happens before the increment.
- `wrap` is high in the same cycle `dout[0]` rises after a rollover, and for 1 cycle only.

## Structure
- Package `decoder_pkg` contains:
  - mode enum (MODE_LEVEL, MODE_PULSE, MODE_SCAN, MODE_RSVD);
  - state enum (ST_IDLE, ST_HOLD, ST_PULSE, ST_SCAN);
  - function `onehot(sel)` returning `1 << sel`.
- Sub-module `decoder_nto2n_core`: purely combinational, parametrised by SEL_W, with inputs `din` and `en` and output `dout`. It is instantiated on the next-state `idx` path. Registers, FSM and counters live in the top level.

## Test plan
All scenarios use SEL_W=3, DWELL_W=8.
- Reset behaviour: hold `rst_n` low, then release → `dout` = 8'h00, `idx` = 0, `busy` = 0. Assert `rst_n` low mid-SCAN → `dout` = 0 before the next edge.
- LEVEL: `load`, mode 0, `din` = 5 → next cycle `dout` = 8'h20, `idx` = 5, held for 20 cycles. Change `din` to 2 without `load` → still 8'h20.
- PULSE: loads on 3 consecutive cycles with `din` = 1, 4, 7 → `dout` = 8'h02, 8'h10, 8'h80 on consecutive cycles, then 8'h00 and `busy` = 0.
- SCAN: `din` = 6, `dwell` = 2 → `dout` = 8'h40 for 3 cycles, then 8'h80 for 3 cycles, then 8'h01 with `wrap` = 1 in its first cycle only. Next wrap occurs 24 cycles later.
- Priority:
  - `en` = 0 together with `load` → `dout` = 0, state IDLE.
  - `load` mid-SCAN with `din` = 3, `dwell` = 0 → `dout` = 8'h08, then advances every cycle.
  - mode 3 → `dout` = 0, `busy` = 0.
- Random stress: random `load`/`mode`/`en` → one-hot-or-zero invariant holds every cycle, and `dout` always equals onehot(`idx`) when nonzero.
